tmark_gen: RTL and testbench

Generates the synchroniser timing markers on a common clock:
- TNO: start of observation.
- TNC: start of cycle.
- TNI/TKI: emission start/end.
- TNP/TKP: reception start/end.
- TOBM: observation-active level.

It drives the marker inputs of the test-signal multiplexer and the rest of the synchroniser. Timing comes from run-time configuration words, latched at start.

---
 rtl/tmark_gen.sv | 269 ++++++++++++++++++++++++++
 tb/tb_tmark_gen.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tmark_gen.sv
// -----------------------------------------------------------------------------
// tmark_gen -- synchroniser timing-marker generator
//
// Produces the per-observation timing markers on a single clock:
//   TNO  start of observation     TNC  start of each cycle
//   TNI  emission start           TKI  emission end
//   TNP  reception start          TKP  reception end
//   TOBM observation-active level
// All timing comes from configuration words captured when an observation
// starts. Changing cfg_* while running has no effect until the next start.
//
// Ports:
//   clk           system clock, rising edge
//   rst           asynchronous active-high reset
//   start         one-clock request to begin an observation (ignored when busy)
//   stop          abort request, priority over start
//   cfg_period    cycle length in clocks (values below 2 are taken as 2)
//   cfg_ncyc      cycles per observation (0 is taken as 1)
//   cfg_ti_start  TNI offset from cycle start
//   cfg_ti_len    TKI offset from TNI
//   cfg_tp_start  TNP offset from cycle start
//   cfg_tp_len    TKP offset from TNP
//   TNO..TKP      one-clock registered marker pulses
//   TOBM, busy    high for every clock of an observation
//   done          one-clock pulse after a normal (non-aborted) completion
//
// Build option:
//   TMARK_REPEAT_EN  when defined, a completed observation restarts at once
//                    with the held configuration; only stop or rst ends it.
// -----------------------------------------------------------------------------
module tmark_gen #(
  parameter int CNT_W  = 24,
  parameter int NCYC_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic [CNT_W-1:0]  cfg_period,
  input  logic [NCYC_W-1:0] cfg_ncyc,
  input  logic [CNT_W-1:0]  cfg_ti_start,
  input  logic [CNT_W-1:0]  cfg_ti_len,
  input  logic [CNT_W-1:0]  cfg_tp_start,
  input  logic [CNT_W-1:0]  cfg_tp_len,
  output logic              TNO,
  output logic              TNC,
  output logic              TNI,
  output logic              TKI,
  output logic              TNP,
  output logic              TKP,
  output logic              TOBM,
  output logic              busy,
  output logic              done
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Sequencer state
  state_t             state_r;
  state_t             state_s;
  logic [CNT_W-1:0]   cnt_r;
  logic [CNT_W-1:0]   cnt_s;
  logic [NCYC_W-1:0]  cyc_r;
  logic [NCYC_W-1:0]  cyc_s;
  logic               fin_r;
  logic               fin_s;
  logic               latch_s;

  // Configuration captured at start. Event offsets are held one bit wider
  // than the counter so that start+len never wraps back into the cycle.
  logic [CNT_W-1:0]   period_r;
  logic [NCYC_W-1:0]  ncyc_r;
  logic [CNT_W:0]     ni_off_r;
  logic [CNT_W:0]     ki_off_r;
  logic [CNT_W:0]     np_off_r;
  logic [CNT_W:0]     kp_off_r;

  // Clamped / widened views of the configuration inputs
  logic [CNT_W-1:0]   period_clamp_s;
  logic [NCYC_W-1:0]  ncyc_clamp_s;
  logic [CNT_W:0]     ki_sum_s;
  logic [CNT_W:0]     kp_sum_s;

  // Derived terminal values and widened counter for offset compares
  logic [CNT_W-1:0]   cnt_last_s;
  logic [NCYC_W-1:0]  cyc_last_s;
  logic [CNT_W:0]     cnt_ext_s;

  // Next values of the registered outputs
  logic               tno_s;
  logic               tnc_s;
  logic               tni_s;
  logic               tki_s;
  logic               tnp_s;
  logic               tkp_s;
  logic               obs_s;
  logic               done_s;

  // Clamp period/ncyc and form the no-wrap end offsets from the live cfg inputs
  always_comb begin
    period_clamp_s = cfg_period;
    ncyc_clamp_s   = cfg_ncyc;
    if (cfg_period < CNT_W'(2)) begin
      period_clamp_s = CNT_W'(2);
    end else begin
      period_clamp_s = cfg_period;
    end
    if (cfg_ncyc == {NCYC_W{1'b0}}) begin
      ncyc_clamp_s = NCYC_W'(1);
    end else begin
      ncyc_clamp_s = cfg_ncyc;
    end
    ki_sum_s = {1'b0, cfg_ti_start} + {1'b0, cfg_ti_len};
    kp_sum_s = {1'b0, cfg_tp_start} + {1'b0, cfg_tp_len};
  end

  // Terminal counts of the latched configuration (period>=2, ncyc>=1 while running)
  always_comb begin
    cnt_last_s = period_r - CNT_W'(1);
    cyc_last_s = ncyc_r - NCYC_W'(1);
    cnt_ext_s  = {1'b0, cnt_r};
  end

  // Next-state, counter and marker decode
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    cyc_s   = cyc_r;
    latch_s = 1'b0;
    fin_s   = 1'b0;
    tno_s   = 1'b0;
    tnc_s   = 1'b0;
    tni_s   = 1'b0;
    tki_s   = 1'b0;
    tnp_s   = 1'b0;
    tkp_s   = 1'b0;
    obs_s   = 1'b0;
    // A completion flagged on the previous edge becomes the done pulse now
    done_s  = fin_r;

    case (state_r)
      ST_IDLE: begin
        if (start && !stop) begin
          state_s = ST_RUN;
          latch_s = 1'b1;
          cnt_s   = {CNT_W{1'b0}};
          cyc_s   = {NCYC_W{1'b0}};
        end else begin
          state_s = ST_IDLE;
        end
      end

      ST_RUN: begin
        if (stop) begin
          // Abort: everything due on this edge is suppressed, including done
          state_s = ST_IDLE;
          cnt_s   = {CNT_W{1'b0}};
          cyc_s   = {NCYC_W{1'b0}};
          done_s  = 1'b0;
        end else begin
          // Markers reflect the counter value of the clock just finished,
          // which puts TNO one clock after the start edge. Because cnt is
          // always below period, offsets >= period can never match.
          obs_s = 1'b1;
          tnc_s = (cnt_r == {CNT_W{1'b0}});
          tno_s = (cnt_r == {CNT_W{1'b0}}) && (cyc_r == {NCYC_W{1'b0}});
          tni_s = (cnt_ext_s == ni_off_r);
          tki_s = (cnt_ext_s == ki_off_r);
          tnp_s = (cnt_ext_s == np_off_r);
          tkp_s = (cnt_ext_s == kp_off_r);

          if (cnt_r == cnt_last_s) begin
            cnt_s = {CNT_W{1'b0}};
            if (cyc_r == cyc_last_s) begin
              cyc_s = {NCYC_W{1'b0}};
              fin_s = 1'b1;
`ifdef TMARK_REPEAT_EN
              state_s = ST_RUN;
`else
              state_s = ST_IDLE;
`endif
            end else begin
              cyc_s = cyc_r + NCYC_W'(1);
            end
          end else begin
            cnt_s = cnt_r + CNT_W'(1);
          end
        end
      end

      default: begin
        state_s = ST_IDLE;
        cnt_s   = {CNT_W{1'b0}};
        cyc_s   = {NCYC_W{1'b0}};
        done_s  = 1'b0;
      end
    endcase
  end

  // State, position counters and completion flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      cnt_r   <= {CNT_W{1'b0}};
      cyc_r   <= {NCYC_W{1'b0}};
      fin_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      cyc_r   <= cyc_s;
      fin_r   <= fin_s;
    end
  end

  // Configuration capture on the accepted start edge, held otherwise
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      period_r <= {CNT_W{1'b0}};
      ncyc_r   <= {NCYC_W{1'b0}};
      ni_off_r <= {(CNT_W+1){1'b0}};
      ki_off_r <= {(CNT_W+1){1'b0}};
      np_off_r <= {(CNT_W+1){1'b0}};
      kp_off_r <= {(CNT_W+1){1'b0}};
    end else if (latch_s) begin
      period_r <= period_clamp_s;
      ncyc_r   <= ncyc_clamp_s;
      ni_off_r <= {1'b0, cfg_ti_start};
      ki_off_r <= ki_sum_s;
      np_off_r <= {1'b0, cfg_tp_start};
      kp_off_r <= kp_sum_s;
    end else begin
      period_r <= period_r;
      ncyc_r   <= ncyc_r;
      ni_off_r <= ni_off_r;
      ki_off_r <= ki_off_r;
      np_off_r <= np_off_r;
      kp_off_r <= kp_off_r;
    end
  end

  // Registered marker, level and completion outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      TNO  <= 1'b0;
      TNC  <= 1'b0;
      TNI  <= 1'b0;
      TKI  <= 1'b0;
      TNP  <= 1'b0;
      TKP  <= 1'b0;
      TOBM <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      TNO  <= tno_s;
      TNC  <= tnc_s;
      TNI  <= tni_s;
      TKI  <= tki_s;
      TNP  <= tnp_s;
      TKP  <= tkp_s;
      TOBM <= obs_s;
      busy <= obs_s;
      done <= done_s;
    end
  end

endmodule

// File: tb/tb_tmark_gen.sv
// -----------------------------------------------------------------------------
// tb_tmark_gen -- self-checking bench for tmark_gen
//
// Output vectors are packed as {TNO,TNC,TNI,TKI,TNP,TKP,TOBM,busy,done}.
// Clock t is the clock period following the t-th rising edge after the edge
// that sampled start (t=0 is the period right after the start edge).
// The reference model derives each clock's outputs arithmetically from the
// clock index: r=t-1, k=r mod period, c=r div period.
// -----------------------------------------------------------------------------
module tb_tmark_gen;

  localparam int CNT_W  = 24;
  localparam int NCYC_W = 8;

  localparam logic [8:0] B_TNO  = 9'b100000000;
  localparam logic [8:0] B_TNC  = 9'b010000000;
  localparam logic [8:0] B_TNI  = 9'b001000000;
  localparam logic [8:0] B_TKI  = 9'b000100000;
  localparam logic [8:0] B_TNP  = 9'b000010000;
  localparam logic [8:0] B_TKP  = 9'b000001000;
  localparam logic [8:0] B_OBS  = 9'b000000110;
  localparam logic [8:0] B_DONE = 9'b000000001;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              stop;
  logic [CNT_W-1:0]  cfg_period;
  logic [NCYC_W-1:0] cfg_ncyc;
  logic [CNT_W-1:0]  cfg_ti_start;
  logic [CNT_W-1:0]  cfg_ti_len;
  logic [CNT_W-1:0]  cfg_tp_start;
  logic [CNT_W-1:0]  cfg_tp_len;
  logic TNO, TNC, TNI, TKI, TNP, TKP, TOBM, busy, done;

  int total = 0;
  int bad   = 0;

  tmark_gen #(.CNT_W(CNT_W), .NCYC_W(NCYC_W)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .cfg_period(cfg_period), .cfg_ncyc(cfg_ncyc),
    .cfg_ti_start(cfg_ti_start), .cfg_ti_len(cfg_ti_len),
    .cfg_tp_start(cfg_tp_start), .cfg_tp_len(cfg_tp_len),
    .TNO(TNO), .TNC(TNC), .TNI(TNI), .TKI(TKI), .TNP(TNP), .TKP(TKP),
    .TOBM(TOBM), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic       start;
    logic       stop;
    logic [8:0] exp;
  } vec_t;

  vec_t tbl[26];

  function automatic logic [8:0] got_vec();
    return {TNO, TNC, TNI, TKI, TNP, TKP, TOBM, busy, done};
  endfunction

  task automatic check(input string name, input int t, input logic [8:0] exp);
    logic [8:0] g;
    g = got_vec();
    total++;
    if (g !== exp) begin
      bad++;
      $display("FAIL %s t=%0d got=%b exp=%b", name, t, g, exp);
    end
  endtask

  // Reference: outputs at clock t of a run started with the given config.
  function automatic logic [8:0] model(input int t, input int p_in, input int n_in,
                                       input int tis, input int til,
                                       input int tps, input int tpl,
                                       input int stop_at);
    logic [8:0] e;
    int p, n, pn, r, k, c;
    logic dn;
    e = 9'b0;
    p = (p_in < 2) ? 2 : p_in;
    n = (n_in == 0) ? 1 : n_in;
    pn = p * n;
    if (t < 1) return 9'b0;
    if (stop_at > 0 && t >= stop_at) return 9'b0;
    r = t - 1;
`ifdef TMARK_REPEAT_EN
    dn = (t > 1) && ((t - 1) % pn == 0);
    r  = r % pn;
`else
    dn = (t == pn + 1);
    if (r >= pn) return {8'b0, dn};
`endif
    k = r % p;
    c = r / p;
    e[8] = (k == 0) && (c == 0);
    e[7] = (k == 0);
    e[6] = (k == tis);
    e[5] = (k == tis + til);
    e[4] = (k == tps);
    e[3] = (k == tps + tpl);
    e[2] = 1'b1;
    e[1] = 1'b1;
    e[0] = dn;
    return e;
  endfunction

  // One observation: start with cfg, optionally scramble inputs while running,
  // optional stop before edge stop_at, compare every clock with the model.
  task automatic run_check(input string name, input int p, input int n,
                           input int tis, input int til, input int tps, input int tpl,
                           input int stop_at_in, input bit junk);
    int pe, ne, pn, last, stop_at;
    pe = (p < 2) ? 2 : p;
    ne = (n == 0) ? 1 : n;
    pn = pe * ne;
    stop_at = stop_at_in;
`ifdef TMARK_REPEAT_EN
    if (stop_at == 0) stop_at = 2 * pn + 2;
`endif
    cfg_period   = 24'(p);
    cfg_ncyc     = 8'(n);
    cfg_ti_start = 24'(tis);
    cfg_ti_len   = 24'(til);
    cfg_tp_start = 24'(tps);
    cfg_tp_len   = 24'(tpl);
    start = 1'b1;
    stop  = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    check(name, 0, 9'b0);
    last = (stop_at > 0) ? stop_at + 2 : pn + 3;
    for (int t = 1; t <= last; t++) begin
      if (junk) begin
        cfg_period   = 24'($urandom);
        cfg_ncyc     = 8'($urandom);
        cfg_ti_start = 24'($urandom_range(0, 5));
        cfg_ti_len   = 24'($urandom_range(0, 5));
        cfg_tp_start = 24'($urandom_range(0, 5));
        cfg_tp_len   = 24'($urandom_range(0, 5));
        start = ((stop_at == 0 || t < stop_at) && t <= pn) ? 1'($urandom_range(0, 1)) : 1'b0;
      end
      stop = (t == stop_at);
      @(posedge clk); #1;
      check(name, t, model(t, p, n, tis, til, tps, tpl, stop_at));
    end
    start = 1'b0;
    stop  = 1'b0;
  endtask

  initial begin
    int p, n, tis, til, tps, tpl, sa, pn;

    rst = 1'b1; start = 1'b0; stop = 1'b0;
    cfg_period = 24'd0; cfg_ncyc = 8'd0;
    cfg_ti_start = 24'd0; cfg_ti_len = 24'd0;
    cfg_tp_start = 24'd0; cfg_tp_len = 24'd0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset", 0, 9'b0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("reset_idle", 0, 9'b0);

    // Table: period=10 ncyc=2 ti=2/3 tp=6/2
    for (int i = 0; i < 26; i++) tbl[i] = '{1'b0, 1'b0, 9'b0};
    tbl[0].start = 1'b1;
    for (int i = 1; i <= 20; i++) tbl[i].exp = B_OBS;
    tbl[1].exp  = tbl[1].exp  | B_TNO | B_TNC;
    tbl[11].exp = tbl[11].exp | B_TNC;
    tbl[3].exp  = tbl[3].exp  | B_TNI;
    tbl[13].exp = tbl[13].exp | B_TNI;
    tbl[6].exp  = tbl[6].exp  | B_TKI;
    tbl[16].exp = tbl[16].exp | B_TKI;
    tbl[7].exp  = tbl[7].exp  | B_TNP;
    tbl[17].exp = tbl[17].exp | B_TNP;
    tbl[9].exp  = tbl[9].exp  | B_TKP;
    tbl[19].exp = tbl[19].exp | B_TKP;
`ifdef TMARK_REPEAT_EN
    tbl[21].exp = B_DONE | B_TNO | B_TNC | B_OBS;
    tbl[22].stop = 1'b1;
`else
    tbl[21].exp = B_DONE;
`endif
    cfg_period = 24'd10; cfg_ncyc = 8'd2;
    cfg_ti_start = 24'd2; cfg_ti_len = 24'd3;
    cfg_tp_start = 24'd6; cfg_tp_len = 24'd2;
    for (int i = 0; i < 26; i++) begin
      start = tbl[i].start;
      stop  = tbl[i].stop;
      if (i == 5) begin
        // mid-run cfg change must not disturb the latched timing
        cfg_period = 24'd3; cfg_ti_start = 24'd0; cfg_tp_start = 24'd1;
      end
      @(posedge clk); #1;
      check("table", i, tbl[i].exp);
    end
    start = 1'b0;
    stop  = 1'b0;

    // Offsets reaching or past the period never fire
    run_check("offset_oob", 8, 2, 5, 4, 9, 0, 0, 1'b0);
    // Clamp period=0 -> 2, ncyc=0 -> 1
    run_check("clamp", 0, 0, 0, 0, 1, 0, 0, 1'b0);
    // Carry into bit CNT_W must not wrap back to an in-range offset
    run_check("no_wrap", 6, 1, 1, 24'hFFFFFF, 2, 24'hFFFFFE, 0, 1'b0);

    // Abort at k=4 of cycle 1, then a fresh run
    run_check("stop", 10, 2, 2, 3, 6, 2, 16, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("after_stop", i, 9'b0);
    end
    run_check("restart", 10, 2, 2, 3, 6, 2, 0, 1'b0);

    // Asynchronous reset mid-run with cfg changed during the run
    cfg_period = 24'd10; cfg_ncyc = 8'd2;
    cfg_ti_start = 24'd2; cfg_ti_len = 24'd3;
    cfg_tp_start = 24'd6; cfg_tp_len = 24'd2;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cfg_period = 24'd5; cfg_ti_start = 24'd1;
    for (int t = 1; t <= 5; t++) begin
      @(posedge clk); #1;
      check("pre_rst", t, model(t, 10, 2, 2, 3, 6, 2, 0));
    end
    #2;
    rst = 1'b1;
    #1;
    check("rst_async", 0, 9'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_held", 0, 9'b0);
    run_check("post_rst", 5, 2, 1, 3, 6, 2, 0, 1'b0);

`ifdef TMARK_REPEAT_EN
    run_check("repeat", 4, 1, 1, 1, 2, 1, 14, 1'b0);
`endif

    // Randomized runs
    for (int r = 0; r < 40; r++) begin
      p   = $urandom_range(0, 12);
      n   = $urandom_range(0, 3);
      tis = $urandom_range(0, 13);
      til = ($urandom_range(0, 7) == 0) ? 24'hFFFFFF : $urandom_range(0, 6);
      tps = $urandom_range(0, 13);
      tpl = $urandom_range(0, 6);
      pn  = ((p < 2) ? 2 : p) * ((n == 0) ? 1 : n);
      sa  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, pn) : 0;
      run_check("random", p, n, tis, til, tps, tpl, sa, 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
